// File: rtl/osd_overlay.sv
// rtl/osd_overlay.sv - 256x64 monochrome OSD overlay with SPI-loaded bitmap
module osd_overlay #(
    parameter int         COLOR_DEPTH  = 6,
    parameter logic [2:0] OSD_COLOR    = 3'b110,
    parameter logic [9:0] OSD_X_OFFSET = 10'd0,
    parameter logic [9:0] OSD_Y_OFFSET = 10'd0
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic                   pixel_ena,
    input  logic                   spi_sck,
    input  logic                   spi_ss3,
    input  logic                   spi_sdi,
    input  logic                   hs_in,
    input  logic                   vs_in,
    input  logic                   hb_in,
    input  logic                   vb_in,
    input  logic [COLOR_DEPTH-1:0] r_in,
    input  logic [COLOR_DEPTH-1:0] g_in,
    input  logic [COLOR_DEPTH-1:0] b_in,
    output logic                   hs_out,
    output logic                   vs_out,
    output logic                   hb_out,
    output logic                   vb_out,
    output logic [COLOR_DEPTH-1:0] r_out,
    output logic [COLOR_DEPTH-1:0] g_out,
    output logic [COLOR_DEPTH-1:0] b_out,
    output logic                   osd_enable
);

    typedef enum logic [1:0] {SPI_IDLE, SPI_WRITE, SPI_SKIP} spi_state_t;

    spi_state_t  spi_state, spi_next;
    logic [2:0]  sck_s;
    logic [1:0]  ss_s, sdi_s;
    logic        ss_armed;
    logic [2:0]  bit_cnt;
    logic [6:0]  shift_q;
    logic [10:0] wr_addr;
    logic        ram_we;
    logic [10:0] ram_waddr;
    logic [7:0]  ram_wdata;
    logic        osd_en_req;
    logic        sck_rise, ss_high, byte_done;
    logic [7:0]  rx_byte;

    assign sck_rise  = sck_s[1] & ~sck_s[2];
    assign ss_high   = ss_s[1];
    assign rx_byte   = {shift_q, sdi_s[1]};
    // A byte only counts once ss has been seen high since reset, so a reset
    // in the middle of a transaction needs a fresh select to resync.
    assign byte_done = sck_rise & ~ss_high & ss_armed & (bit_cnt == 3'd7);

    // Two-flop synchronizers for the SPI pins, plus one extra sck stage for edge detection
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sck_s <= '0;
            ss_s  <= '0;
            sdi_s <= '0;
        end else begin
            sck_s <= {sck_s[1:0], spi_sck};
            ss_s  <= {ss_s[0], spi_ss3};
            sdi_s <= {sdi_s[0], spi_sdi};
        end
    end

    // SPI command state register
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) spi_state <= SPI_IDLE;
        else       spi_state <= spi_next;
    end

    // First byte selects WRITE or SKIP; ss high always returns to IDLE
    always_comb begin
        spi_next = spi_state;
        if (ss_high)
            spi_next = SPI_IDLE;
        else if (byte_done && spi_state == SPI_IDLE)
            spi_next = (rx_byte[7:3] == 5'b00100) ? SPI_WRITE : SPI_SKIP;
    end

    // Bit shifting, command decode and the one-cycle RAM write strobe
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ss_armed   <= 1'b0;
            bit_cnt    <= '0;
            shift_q    <= '0;
            wr_addr    <= '0;
            ram_we     <= 1'b0;
            ram_waddr  <= '0;
            ram_wdata  <= '0;
            osd_en_req <= 1'b0;
        end else begin
            ram_we <= 1'b0;
            if (ss_high) begin
                ss_armed <= 1'b1;
                bit_cnt  <= '0;
            end else if (sck_rise) begin
                bit_cnt <= bit_cnt + 3'd1;
                shift_q <= {shift_q[5:0], sdi_s[1]};
            end
            if (byte_done) begin
                case (spi_state)
                    SPI_IDLE: begin
                        if (rx_byte[7:3] == 5'b00100) wr_addr <= {rx_byte[2:0], 8'h00};
                        if (rx_byte == 8'h40) osd_en_req <= 1'b0;
                        if (rx_byte == 8'h41) osd_en_req <= 1'b1;
                    end
                    SPI_WRITE: begin
                        ram_we    <= 1'b1;
                        ram_waddr <= wr_addr;
                        ram_wdata <= rx_byte;
                        wr_addr   <= wr_addr + 11'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    logic [7:0]  osd_ram [0:2047];
    logic [7:0]  ram_q;
    logic [10:0] rd_addr;

    // Port A: SPI writes
    always_ff @(posedge clk_sys) begin
        if (ram_we) osd_ram[ram_waddr] <= ram_wdata;
    end

    // Port B: display read, fetched one pixel ahead of its use
    always_ff @(posedge clk_sys) begin
        if (pixel_ena) ram_q <= osd_ram[rd_addr];
    end

    logic              hs_d, vs_d;
    logic [9:0]        h_cnt, v_cnt, width, height;
    logic              hs_rise, vs_rise;
    logic [9:0]        h_cnt_inc, v_cnt_inc, h_pos, v_pos;
    logic signed [11:0] h_diff, h_calc, v_diff, v_calc;
    logic [10:0]       h_start, v_start;
    logic [11:0]       rel_h, rel_v;
    logic [7:0]        col_next;
    logic              window, pix_bit, blank;

    assign hs_rise   = hs_in & ~hs_d;
    assign vs_rise   = vs_in & ~vs_d;
    assign h_cnt_inc = (h_cnt == 10'd1023) ? h_cnt : h_cnt + 10'd1;
    assign v_cnt_inc = (v_cnt == 10'd1023) ? v_cnt : v_cnt + 10'd1;
    // Position of the pixel currently on the inputs
    assign h_pos     = hs_rise ? 10'd0 : h_cnt_inc;
    assign v_pos     = vs_rise ? 10'd0 : (hs_rise ? v_cnt_inc : v_cnt);

    assign h_diff  = $signed({2'b00, width}) - 12'sd256;
    assign h_calc  = (h_diff >>> 1) + $signed({{2{OSD_X_OFFSET[9]}}, OSD_X_OFFSET});
    assign h_start = h_calc[11] ? 11'd0 : h_calc[10:0];
    assign v_diff  = $signed({2'b00, height}) - 12'sd64;
    assign v_calc  = (v_diff >>> 1) + $signed({{2{OSD_Y_OFFSET[9]}}, OSD_Y_OFFSET});
    assign v_start = v_calc[11] ? 11'd0 : v_calc[10:0];

    assign rel_h    = {2'b00, h_pos} - {1'b0, h_start};
    assign rel_v    = {2'b00, v_pos} - {1'b0, v_start};
    assign col_next = h_pos[7:0] + 8'd1 - h_start[7:0];
    assign rd_addr  = {rel_v[5:3], col_next};

    assign window = osd_enable & (width >= 10'd256) & (height >= 10'd64)
                  & ~rel_h[11] & (rel_h[10:8] == 3'd0)
                  & ~rel_v[11] & (rel_v[10:6] == 5'd0);
    assign pix_bit = ram_q[rel_v[2:0]];
    assign blank   = hb_in | vb_in;

    // Line/frame measurement; osd_enable is sampled once per frame
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            hs_d       <= 1'b0;
            vs_d       <= 1'b0;
            h_cnt      <= '0;
            v_cnt      <= '0;
            width      <= '0;
            height     <= '0;
            osd_enable <= 1'b0;
        end else if (pixel_ena) begin
            hs_d  <= hs_in;
            vs_d  <= vs_in;
            h_cnt <= h_pos;
            v_cnt <= v_pos;
            if (hs_rise) width <= h_cnt_inc;
            if (vs_rise) begin
                height     <= v_cnt_inc;
                osd_enable <= osd_en_req;
            end
        end
    end

    function automatic logic [COLOR_DEPTH-1:0] shade(input logic [COLOR_DEPTH-1:0] v,
                                                     input logic fg, input logic blk,
                                                     input logic win, input logic bit_set);
        logic [COLOR_DEPTH-1:0] res;
        if (blk)          res = '0;
        else if (!win)    res = v;
        else if (bit_set) res = fg ? '1 : '0;
        else              res = {2'b00, v[COLOR_DEPTH-1:2]};
        return res;
    endfunction

    // One-pixel output pipeline for video, syncs and blanks
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            hs_out <= 1'b0;
            vs_out <= 1'b0;
            hb_out <= 1'b0;
            vb_out <= 1'b0;
            r_out  <= '0;
            g_out  <= '0;
            b_out  <= '0;
        end else if (pixel_ena) begin
            hs_out <= hs_in;
            vs_out <= vs_in;
            hb_out <= hb_in;
            vb_out <= vb_in;
            r_out  <= shade(r_in, OSD_COLOR[2], blank, window, pix_bit);
            g_out  <= shade(g_in, OSD_COLOR[1], blank, window, pix_bit);
            b_out  <= shade(b_in, OSD_COLOR[0], blank, window, pix_bit);
        end
    end

endmodule

// File: tb/tb_osd_overlay.sv
// tb/tb_osd_overlay.sv - self-checking bench for osd_overlay
module tb_osd_overlay;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic       reset, pixel_ena, spi_sck, spi_ss3, spi_sdi;
    logic       hs_in, vs_in, hb_in, vb_in;
    logic [5:0] r_in, g_in, b_in, r_out, g_out, b_out;
    logic       hs_out, vs_out, hb_out, vb_out, osd_enable;

    osd_overlay dut (
        .clk_sys(clk_sys), .reset(reset), .pixel_ena(pixel_ena),
        .spi_sck(spi_sck), .spi_ss3(spi_ss3), .spi_sdi(spi_sdi),
        .hs_in(hs_in), .vs_in(vs_in), .hb_in(hb_in), .vb_in(vb_in),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .hs_out(hs_out), .vs_out(vs_out), .hb_out(hb_out), .vb_out(vb_out),
        .r_out(r_out), .g_out(g_out), .b_out(b_out), .osd_enable(osd_enable)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [7:0] m_mem [0:2047];
    bit         m_known [0:2047];
    int         m_wptr = 0;
    bit         m_en_req = 0, m_en_frame = 0;
    int         m_width = 0, m_height = 0, m_last_line = 0, m_last_frame = 0;

    typedef struct {
        logic       hs, vs, hb, vb;
        logic [5:0] r, g, b;
        logic [5:0] er, eg, eb;
    } vec_t;
    vec_t tbl [8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_px(input logic hs, input logic vs, input logic hb, input logic vb,
                            input logic [5:0] r, input logic [5:0] g, input logic [5:0] b);
        @(negedge clk_sys);
        pixel_ena = 1'b1;
        hs_in = hs; vs_in = vs; hb_in = hb; vb_in = vb;
        r_in = r; g_in = g; b_in = b;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic video_idle();
        @(negedge clk_sys);
        pixel_ena = 1'b0;
    endtask

    task automatic spi_bits(input logic [7:0] v, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            spi_sdi = v[i];
            repeat (2) @(negedge clk_sys);
            spi_sck = 1'b1;
            repeat (2) @(negedge clk_sys);
            spi_sck = 1'b0;
        end
    endtask

    task automatic spi_start();
        @(negedge clk_sys);
        spi_ss3 = 1'b0;
        repeat (3) @(negedge clk_sys);
    endtask

    task automatic spi_stop();
        repeat (3) @(negedge clk_sys);
        spi_ss3 = 1'b1;
        repeat (4) @(negedge clk_sys);
    endtask

    task automatic spi_data(input logic [7:0] v);
        spi_bits(v, 8);
        m_mem[m_wptr]   = v;
        m_known[m_wptr] = 1'b1;
        m_wptr          = (m_wptr + 1) % 2048;
    endtask

    function automatic logic [5:0] chan(input logic [5:0] v, input bit blk, input bit win,
                                        input bit pix, input bit fg);
        if (blk)  return 6'd0;
        if (!win) return v;
        if (pix)  return fg ? 6'h3F : 6'h00;
        return v / 4;
    endfunction

    function automatic int centre(input int size, input int span);
        int s;
        s = (size - span) / 2;
        return (s < 0) ? 0 : s;
    endfunction

    // Drives one w x h frame; every output pixel is compared with the model
    task automatic frame(input int w, input int h);
        int         hs0, vs0, a, ln;
        bit         win, blk, known, pix;
        logic       hs, vs, hb, vb;
        logic [5:0] r, g, b;
        logic [17:0] e0, e1, act;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                hs = (x < 8); vs = (y < 2); hb = (x >= w - 2); vb = (y >= h - 1);
                r = 6'($urandom); g = 6'($urandom); b = 6'($urandom);
                if (x == 0) begin
                    m_width = m_last_line;
                    if (y == 0) begin
                        m_height   = m_last_frame;
                        m_en_frame = m_en_req;
                    end
                end
                hs0 = centre(m_width, 256);
                vs0 = centre(m_height, 64);
                win = m_en_frame && m_width >= 256 && m_height >= 64 &&
                      x >= hs0 && x < hs0 + 256 && y >= vs0 && y < vs0 + 64;
                blk = hb || vb;
                known = 1'b0; pix = 1'b0;
                if (win) begin
                    ln    = y - vs0;
                    a     = (ln / 8) * 256 + (x - hs0);
                    known = m_known[a];
                    pix   = known && m_mem[a][ln % 8];
                end
                e0 = {chan(r, blk, win, pix, 1'b1), chan(g, blk, win, pix, 1'b1), chan(b, blk, win, pix, 1'b0)};
                e1 = e0;
                if (win && !known)
                    e1 = {chan(r, blk, win, 1'b1, 1'b1), chan(g, blk, win, 1'b1, 1'b1), chan(b, blk, win, 1'b1, 1'b0)};
                drive_px(hs, vs, hb, vb, r, g, b);
                act = {r_out, g_out, b_out};
                checks++;
                if (act != e0 && act != e1) begin
                    errors++;
                    $display("FAIL pix_rgb x=%0d y=%0d w=%0d: got %05h expected %05h or %05h",
                             x, y, w, act, e0, e1);
                end
                check("pix_sync", {hs_out, vs_out, hb_out, vb_out}, {hs, vs, hb, vb});
                if (x == 0) check("osd_enable", osd_enable, m_en_frame);
            end
            m_last_line = w;
        end
        m_last_frame = h;
        video_idle();
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) m_known[i] = 1'b0;
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'h3F, 6'h00, 6'h00, 6'h3F, 6'h00, 6'h00};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'h15, 6'h2A, 6'h3F, 6'h15, 6'h2A, 6'h3F};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'h01, 6'h02, 6'h03, 6'h01, 6'h02, 6'h03};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 6'h3F, 6'h3F, 6'h3F, 6'h00, 6'h00, 6'h00};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 6'h10, 6'h20, 6'h30, 6'h10, 6'h20, 6'h30};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 6'h3F, 6'h3F, 6'h3F, 6'h00, 6'h00, 6'h00};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 6'h22, 6'h11, 6'h05, 6'h00, 6'h00, 6'h00};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 6'h3F, 6'h2C, 6'h00, 6'h3F, 6'h2C};

        reset = 1'b1; pixel_ena = 1'b1;
        spi_sck = 1'b0; spi_ss3 = 1'b1; spi_sdi = 1'b0;
        hs_in = 1'b1; vs_in = 1'b1; hb_in = 1'b1; vb_in = 1'b1;
        r_in = 6'h3F; g_in = 6'h3F; b_in = 6'h3F;
        repeat (3) @(negedge clk_sys);
        check("reset_rgb", {r_out, g_out, b_out}, 0);
        check("reset_sync", {hs_out, vs_out, hb_out, vb_out}, 0);
        check("reset_osd_enable", osd_enable, 0);
        reset = 1'b0; pixel_ena = 1'b0;
        hs_in = 1'b0; vs_in = 1'b0; hb_in = 1'b0; vb_in = 1'b0;
        repeat (4) @(negedge clk_sys);

        // Pass-through with no OSD configured
        for (int i = 0; i < 8; i++) begin
            drive_px(tbl[i].hs, tbl[i].vs, tbl[i].hb, tbl[i].vb, tbl[i].r, tbl[i].g, tbl[i].b);
            check($sformatf("tbl%0d_rgb", i), {r_out, g_out, b_out}, {tbl[i].er, tbl[i].eg, tbl[i].eb});
            check($sformatf("tbl%0d_sync", i), {hs_out, vs_out, hb_out, vb_out},
                  {tbl[i].hs, tbl[i].vs, tbl[i].hb, tbl[i].vb});
            check($sformatf("tbl%0d_osd_enable", i), osd_enable, 0);
        end

        // Outputs hold while pixel_ena is low
        @(negedge clk_sys);
        pixel_ena = 1'b0;
        r_in = 6'h01; g_in = 6'h02; b_in = 6'h03; hb_in = 1'b1;
        repeat (4) @(negedge clk_sys);
        check("hold_rgb", {r_out, g_out, b_out}, {tbl[7].er, tbl[7].eg, tbl[7].eb});
        check("hold_sync", {hs_out, vs_out, hb_out, vb_out}, 0);
        hb_in = 1'b0;

        // Unknown command is ignored, including its trailing byte
        spi_start(); spi_bits(8'h55, 8); spi_bits(8'h20, 8); spi_stop();

        // Fill the first 40 bytes of the top row
        spi_start(); spi_bits(8'h20, 8); m_wptr = 0;
        for (int i = 0; i < 40; i++) spi_data(8'($urandom));
        spi_stop();

        // Overwrite 0..11, then abandon a byte after 5 bits: address 12 keeps its value
        spi_start(); spi_bits(8'h20, 8); m_wptr = 0;
        spi_data(8'h01); spi_data(8'hFF);
        for (int i = 0; i < 10; i++) spi_data(8'($urandom));
        spi_bits(8'h00, 5);
        spi_stop();

        // Next transaction must decode cleanly as a command
        spi_start(); spi_bits(8'h41, 8); spi_stop();
        m_en_req = 1'b1;
        check("osd_enable_before_vs", osd_enable, 0);

        frame(260, 66);
        frame(260, 66);

        // Address wrap: 257th byte after 0x27 lands at 0x000
        spi_start(); spi_bits(8'h27, 8); m_wptr = 12'h700;
        for (int i = 0; i < 256; i++) spi_data(8'($urandom));
        spi_data(8'hFE);
        spi_stop();
        frame(260, 66);

        // Narrow frame suppresses the window
        frame(200, 10);

        spi_start(); spi_bits(8'h40, 8); spi_stop();
        m_en_req = 1'b0;
        check("osd_enable_still_on", osd_enable, 1);
        frame(260, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/osd_overlay.md
Name: osd_overlay

Overview:
- Sits directly downstream of scandoubler; consumes its r/g/b_out, hs/vs_out, hb/vb_out and pixel_ena_x2.
- Overlays a 256x64 monochrome on-screen-display window, centred on the active picture.
- The IO controller loads the bitmap and the enable state over SPI.
- Output drives the VGA pins one pixel-enable after input.

Parameters:
- COLOR_DEPTH, 6, bits per colour on input and output.
- OSD_COLOR, 3'b110, {r,g,b} foreground mask; a channel is all-ones where its bit is set, else zero.
- OSD_X_OFFSET, 0, signed 10-bit horizontal shift added to the centred start.
- OSD_Y_OFFSET, 0, signed 10-bit vertical shift added to the centred start.

Ports:
- clk_sys  in  1  system clock; all logic is synchronous to it.
- reset  in  1  asynchronous active-high reset.
- pixel_ena  in  1  pixel strobe (scandoubler pixel_ena_x2).
- spi_sck  in  1  SPI clock, asynchronous, mode 0.
- spi_ss3  in  1  SPI select, active-low.
- spi_sdi  in  1  SPI data, MSB first.
- hs_in, vs_in, hb_in, vb_in  in  1 each  syncs (active-high) and blanks.
- r_in, g_in, b_in  in  COLOR_DEPTH each  video in.
- hs_out, vs_out, hb_out, vb_out  out  1 each  delayed syncs and blanks.
- r_out, g_out, b_out  out  COLOR_DEPTH each  video out.
- osd_enable  out  1  OSD currently shown.

Behaviour:
Reset:
- All outputs 0, osd_enable 0, SPI state IDLE.
- Measured width and height 0. Buffer contents undefined.

SPI slave:
- sck, ss and sdi each pass through a 2-flop synchronizer; sck rising edge detected in clk_sys.
- ss high: bit counter clears, state IDLE, and any partial byte is discarded.
- The first byte after ss falls is the command:
  - 0x20-0x27: WRITE. addr = {cmd[2:0], 8'h00}; each following byte writes buf[addr] and addr increments. addr wraps from 0x7FF to 0x000.
  - 0x40: osd_enable <= 0. 0x41: osd_enable <= 1.
  - Any other command: ignored until ss rises.
- The write strobe lasts one clk_sys cycle, issued after bit 0 is sampled.
- Buffer: 2048x8 inferred RAM with 1-cycle read latency. Byte {row[2:0], col[7:0]} holds pixel column col, lines row*8..row*8+7, bit0 = top.

Timing measurement (pixel_ena domain):
- h_cnt counts pixel_ena; cleared on hs_in rising edge after latching width <= h_cnt.
- v_cnt counts hs_in rising edges; cleared on vs_in rising edge after latching height <= v_cnt.
- Counters are 10 bits and saturate at 1023.
- h_start = (width-256)/2 + OSD_X_OFFSET. v_start = (height-64)/2 + OSD_Y_OFFSET.
- Computed with 11-bit signed arithmetic and clamped at 0. If width<256 or height<64, the window is suppressed.

Window:
- Active when h_start <= h_cnt < h_start+256, v_start <= v_cnt < v_start+64, and osd_enable=1.
- RAM address is issued one pixel ahead so data is valid at the window pixel.
- osd_enable changes take effect at the next vs_in rising edge (latched per frame).

Pixel pipeline (on pixel_ena only; otherwise all outputs hold):
- Latency is exactly 1 pixel_ena for video, syncs and blanks alike.
- Window and bit set: channel = OSD_COLOR bit ? all ones : 0.
- Window and bit clear: channel = {2'b00, in[COLOR_DEPTH-1:2]}.
- Outside window: channel = in.
- hb_in|vb_in forces colour 0 regardless of window.

Boundaries:
- An SPI write during display is permitted. RAM writes take priority only on port A; display reads use port B, so there is no stall.
- reset asserted mid-byte aborts the transaction; the next transaction needs a fresh ss fall.

Test Plan:
- Reset then release, input r=0x3F with no SPI traffic -> r_out=0x3F after 1 pixel_ena; osd_enable=0.
- Frame 640 pixels x 480 lines; SPI 0x41 then a vs edge -> window at h 192..447, v 208..271; r_in=0x3F inside with bits clear -> r_out=0x0F.
- SPI 0x20 then bytes 0x01,0xFF; frame 640x480 -> pixel (192,208): r=0x3F, g=0x3F, b=0 (OSD_COLOR=110). Pixel (193,209): r=g=0x3F. Pixel (192,209): darkened.
- Write 0x27 followed by 257 bytes -> the final byte lands at addr 0x000 (wrap); displayed at column 0, top row.
- Frame 200x480 -> window suppressed; output equals input delayed by 1 pixel_ena.
- ss raised after 5 bits of a data byte -> no RAM write; the next transaction is decoded correctly.
